// File: rtl/falafel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : falafel_pkg
// Purpose  : Shared types, register bit positions and strobe-merge helper.
// Revision : 1.0
// ============================================================================
package falafel_pkg;

    typedef enum logic [0:0] {
        CFG_IDLE = 1'b0,
        CFG_RESP = 1'b1
    } cfg_fsm_e;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_LOCK_BIT   = 1;
    localparam int STAT_PEND_BIT   = 0;
    localparam int STAT_LOCK_BIT   = 1;
    localparam int STAT_ERR_BIT    = 2;

    // Widest register the merge helper supports; callers extend and truncate.
    localparam int CFG_MAX_W      = 1024;
    localparam int CFG_MAX_STRB_W = CFG_MAX_W / 8;

    function automatic logic [CFG_MAX_W-1:0] cfg_strb_merge(
        input logic [CFG_MAX_W-1:0]      old_val,
        input logic [CFG_MAX_W-1:0]      new_val,
        input logic [CFG_MAX_STRB_W-1:0] strb
    );
        logic [CFG_MAX_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < CFG_MAX_STRB_W; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/falafel_cfg_strb_reg.sv
`default_nettype none
// ============================================================================
// Module   : falafel_cfg_strb_reg
// Purpose  : One DATA_W register with per-byte write enables.
// Revision : 1.0
// ============================================================================
module falafel_cfg_strb_reg
    import falafel_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else if (we) begin
            r_q <= DATA_W'(cfg_strb_merge(CFG_MAX_W'(r_q), CFG_MAX_W'(wdata),
                                          CFG_MAX_STRB_W'(strb)));
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/falafel_config_regfile.sv
`default_nettype none
// ============================================================================
// Module   : falafel_config_regfile
// Purpose  : Shadow/active config register file with commit-on-idle and lock.
// Revision : 1.0
// ============================================================================
module falafel_config_regfile
    import falafel_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int NUM_CFG = 4,
    parameter int IDX_W   = $clog2(NUM_CFG + 2)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [DATA_W-1:0]         req_addr_i,
    input  logic [DATA_W-1:0]         req_data_i,
    input  logic [DATA_W/8-1:0]       req_strb_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      rsp_err_o,
    input  logic                      idle_i,
    output logic [NUM_CFG*DATA_W-1:0] config_o,
    output logic                      config_update_o
);

    localparam int              C_BYTE_OFF = $clog2(DATA_W / 8);
    localparam int              C_WORD_W   = DATA_W - C_BYTE_OFF;
    localparam logic [IDX_W-1:0] C_CTRL_IDX = IDX_W'(NUM_CFG);
    localparam logic [IDX_W-1:0] C_STAT_IDX = IDX_W'(NUM_CFG + 1);

    cfg_fsm_e            r_state;
    cfg_fsm_e            w_state_nxt;
    logic [C_WORD_W-1:0] w_word;
    logic [IDX_W-1:0]    w_idx;
    logic                w_upper;
    logic                w_is_shadow;
    logic                w_is_ctrl;
    logic                w_is_stat;
    logic                w_range_err;
    logic                w_accept;
    logic                w_req_err;
    logic                w_wr_ok;
    logic                w_ctrl_commit;
    logic                w_ctrl_lock;
    logic                w_stat_rd;
    logic                w_commit_fire;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_shadow [NUM_CFG];
    logic [DATA_W-1:0]   r_active [NUM_CFG];
    logic                r_pending;
    logic                r_locked;
    logic                r_err_sticky;
    logic                r_cfg_update;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;

    // Any set bit above the index field makes the address illegal.
    assign w_word  = req_addr_i[DATA_W-1:C_BYTE_OFF];
    assign w_idx   = w_word[IDX_W-1:0];
    assign w_upper = |w_word[C_WORD_W-1:IDX_W];

    generate
        if (C_BYTE_OFF > 0) begin : g_addr_lsb
            logic w_unused_addr_lsb;
            assign w_unused_addr_lsb = ^req_addr_i[C_BYTE_OFF-1:0];
        end
    endgenerate

    assign w_is_shadow = ~w_upper & (w_idx < C_CTRL_IDX);
    assign w_is_ctrl   = ~w_upper & (w_idx == C_CTRL_IDX);
    assign w_is_stat   = ~w_upper & (w_idx == C_STAT_IDX);
    assign w_range_err = ~(w_is_shadow | w_is_ctrl | w_is_stat);

    assign w_accept  = req_valid_i & (r_state == CFG_IDLE);
    assign w_req_err = w_range_err
                     | (req_write_i & (w_is_stat
                                       | ((w_is_shadow | w_is_ctrl) & r_locked)
                                       | (w_is_shadow & r_pending)));
    assign w_wr_ok       = w_accept & req_write_i & ~w_req_err;
    assign w_ctrl_commit = w_wr_ok & w_is_ctrl & req_data_i[CTRL_COMMIT_BIT];
    assign w_ctrl_lock   = w_wr_ok & w_is_ctrl & req_data_i[CTRL_LOCK_BIT];
    assign w_stat_rd     = w_accept & ~req_write_i & w_is_stat;
    assign w_commit_fire = r_pending & idle_i;

    generate
        for (genvar k = 0; k < NUM_CFG; k++) begin : g_shadow
            falafel_cfg_strb_reg #(
                .DATA_W (DATA_W)
            ) u_reg (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .we     (w_wr_ok & w_is_shadow & (w_idx == IDX_W'(k))),
                .wdata  (req_data_i),
                .strb   (req_strb_i),
                .q      (w_shadow[k])
            );
            assign config_o[k*DATA_W +: DATA_W] = r_active[k];
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        if (!req_write_i) begin
            if (w_is_shadow) begin
                for (int k = 0; k < NUM_CFG; k++) begin
                    if (w_idx == IDX_W'(k)) begin
                        w_rdata = w_shadow[k];
                    end
                end
            end else if (w_is_ctrl) begin
                w_rdata[CTRL_COMMIT_BIT] = r_pending;
                w_rdata[CTRL_LOCK_BIT]   = r_locked;
            end else if (w_is_stat) begin
                w_rdata[STAT_PEND_BIT] = r_pending;
                w_rdata[STAT_LOCK_BIT] = r_locked;
                w_rdata[STAT_ERR_BIT]  = r_err_sticky;
            end
        end
    end

    // A commit request arriving while one is outstanding merges into it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending    <= 1'b0;
            r_locked     <= 1'b0;
            r_err_sticky <= 1'b0;
            r_cfg_update <= 1'b0;
            for (int k = 0; k < NUM_CFG; k++) begin
                r_active[k] <= '0;
            end
        end else begin
            r_pending    <= (r_pending & ~w_commit_fire) | (w_ctrl_commit & ~r_pending);
            r_locked     <= r_locked | w_ctrl_lock;
            r_cfg_update <= w_commit_fire;
            if (w_accept & w_req_err) begin
                r_err_sticky <= 1'b1;
            end else if (w_stat_rd) begin
                r_err_sticky <= 1'b0;
            end
            if (w_commit_fire) begin
                for (int k = 0; k < NUM_CFG; k++) begin
                    r_active[k] <= w_shadow[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= CFG_IDLE;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rsp_data <= w_rdata;
                r_rsp_err  <= w_req_err;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            CFG_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_state_nxt = CFG_RESP;
                end
            end
            CFG_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_state_nxt = CFG_IDLE;
                end
            end
            default: w_state_nxt = CFG_IDLE;
        endcase
    end

    assign rsp_data_o      = r_rsp_data;
    assign rsp_err_o       = r_rsp_err;
    assign config_update_o = r_cfg_update;

endmodule
`default_nettype wire

// File: tb/tb_falafel_config_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_falafel_config_regfile
// Purpose  : Directed self-checking bench for falafel_config_regfile.
// Revision : 1.0
// ============================================================================
module tb_falafel_config_regfile;

    localparam int DATA_W  = 64;
    localparam int NUM_CFG = 4;

    localparam logic [63:0] A_SH0  = 64'h00;
    localparam logic [63:0] A_SH1  = 64'h08;
    localparam logic [63:0] A_SH2  = 64'h10;
    localparam logic [63:0] A_SH3  = 64'h18;
    localparam logic [63:0] A_CTRL = 64'h20;
    localparam logic [63:0] A_STAT = 64'h28;

    logic                      clk;
    logic                      rst_n;
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [DATA_W-1:0]         req_addr;
    logic [DATA_W-1:0]         req_data;
    logic [DATA_W/8-1:0]       req_strb;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      idle;
    logic [NUM_CFG*DATA_W-1:0] cfg;
    logic                      cfg_update;

    int n_total = 0;
    int n_bad   = 0;

    falafel_config_regfile #(
        .DATA_W  (DATA_W),
        .NUM_CFG (NUM_CFG)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_write_i     (req_write),
        .req_addr_i      (req_addr),
        .req_data_i      (req_data),
        .req_strb_i      (req_strb),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data),
        .rsp_err_o       (rsp_err),
        .idle_i          (idle),
        .config_o        (cfg),
        .config_update_o (cfg_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    // One full request/response; returns 2 edges later at posedge+1.
    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, output logic [63:0] rdata, output logic rerr);
        check("req_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        req_strb  = strb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        rdata = rsp_data;
        rerr  = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic wr(input string tag, input logic [63:0] addr, input logic [63:0] data,
                      input logic [7:0] strb, input logic exp_err);
        logic [63:0] d;
        logic        e;
        do_req(1'b1, addr, data, strb, d, e);
        check({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
        check({tag, "_data"}, d, 64'd0);
    endtask

    task automatic rd(input string tag, input logic [63:0] addr,
                      input logic [63:0] exp_data, input logic exp_err);
        logic [63:0] d;
        logic        e;
        do_req(1'b0, addr, 64'd0, 8'd0, d, e);
        check({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
        check({tag, "_data"}, d, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        rsp_ready = 1'b1;
        idle      = 1'b0;

        #1;
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_update", {63'd0, cfg_update}, 64'd0);
        check("rst_cfg_zero", {63'd0, cfg == '0}, 64'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        rd("rd_sh0_reset", A_SH0, 64'd0, 1'b0);
        rd("rd_stat_reset", A_STAT, 64'd0, 1'b0);

        wr("wr_sh1_full", A_SH1, 64'h1122334455667788, 8'hFF, 1'b0);
        wr("wr_sh1_low", A_SH1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0);
        wr("wr_sh1_nostrb", A_SH1, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b0);
        rd("rd_sh1_merge", A_SH1, 64'h11223344AAAAAAAA, 1'b0);
        check("cfg1_before_commit", cfg[1*64 +: 64], 64'd0);

        wr("wr_ctrl_commit", A_CTRL, 64'h1, 8'hFF, 1'b0);
        rd("rd_stat_pending", A_STAT, 64'h1, 1'b0);
        check("cfg1_still_old", cfg[1*64 +: 64], 64'd0);
        idle = 1'b1;
        @(posedge clk); #1;
        check("cfg1_committed", cfg[1*64 +: 64], 64'h11223344AAAAAAAA);
        check("update_pulse", {63'd0, cfg_update}, 64'd1);
        @(posedge clk); #1;
        check("update_drop", {63'd0, cfg_update}, 64'd0);
        idle = 1'b0;
        rd("rd_stat_clear", A_STAT, 64'h0, 1'b0);

        wr("wr_ctrl_commit2", A_CTRL, 64'h1, 8'hFF, 1'b0);
        wr("wr_sh0_pending", A_SH0, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1);
        rd("rd_stat_err", A_STAT, 64'h5, 1'b0);
        rd("rd_stat_err_clr", A_STAT, 64'h1, 1'b0);
        rd("rd_oor_idx6", 64'h30, 64'd0, 1'b1);
        rd("rd_oor_upper", 64'h40, 64'd0, 1'b1);
        wr("wr_status", A_STAT, 64'h7, 8'hFF, 1'b1);
        rd("rd_stat_err2", A_STAT, 64'h5, 1'b0);
        rd("rd_ctrl", A_CTRL, 64'h1, 1'b0);
        rd("rd_sh0_kept", A_SH0, 64'd0, 1'b0);
        wr("wr_ctrl_recommit", A_CTRL, 64'h1, 8'hFF, 1'b0);

        idle = 1'b1;
        cnt  = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cfg_update) cnt++;
        end
        idle = 1'b0;
        check("single_commit_pulses", 64'(cnt), 64'd1);
        check("cfg0_after_commit", cfg[0*64 +: 64], 64'd0);
        check("cfg1_after_commit", cfg[1*64 +: 64], 64'h11223344AAAAAAAA);

        wr("wr_ctrl_lock", A_CTRL, 64'h2, 8'hFF, 1'b0);
        wr("wr_sh2_locked", A_SH2, 64'h0123456789ABCDEF, 8'hFF, 1'b1);
        wr("wr_ctrl_locked", A_CTRL, 64'h1, 8'hFF, 1'b1);
        rd("rd_stat_locked", A_STAT, 64'h6, 1'b0);
        rd("rd_sh2_locked", A_SH2, 64'd0, 1'b0);
        check("cfg2_locked", cfg[2*64 +: 64], 64'd0);

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = A_SH1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_data", rsp_data, 64'h11223344AAAAAAAA);
            check("hold_ready", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("async_rst_data", rsp_data, 64'd0);
        check("async_rst_cfg", {63'd0, cfg == '0}, 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        rd("rd_stat_after_rst", A_STAT, 64'h0, 1'b0);
        rd("rd_sh1_after_rst", A_SH1, 64'd0, 1'b0);

        wr("wr_sh3", A_SH3, 64'h0123456789ABCDEF, 8'hFF, 1'b0);
        wr("wr_ctrl_commit_lock", A_CTRL, 64'h3, 8'hFF, 1'b0);
        rd("rd_stat_cl", A_STAT, 64'h3, 1'b0);
        idle = 1'b1;
        @(posedge clk); #1;
        check("cfg3_commit_lock", cfg[3*64 +: 64], 64'h0123456789ABCDEF);
        check("update_commit_lock", {63'd0, cfg_update}, 64'd1);
        idle = 1'b0;
        rd("rd_stat_lock_only", A_STAT, 64'h2, 1'b0);
        wr("wr_sh3_locked", A_SH3, 64'h0, 8'hFF, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/falafel_config_regfile.md
Name: falafel_config_regfile

Overview:
Parametrised configuration register file for the falafel allocator core. It is the successor to the fixed single-shot config register block.
- Host side: valid/ready request/response port with byte strobes and read-back.
- Staging: host writes land in shadow registers.
- Commit: shadow values are copied atomically into the active config only while the core reports idle.
- Protection: a lock bit freezes configuration until reset.

Parameters:
DATA_W, 64, register and bus width in bits; must be a multiple of 8
NUM_CFG, 4, number of configuration registers (1..16)
IDX_W, $clog2(NUM_CFG+2), width of the word-index field

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
req_valid_i  input  1  host request valid
req_ready_o  output  1  block can accept a request
req_write_i  input  1  1 = write, 0 = read
req_addr_i  input  DATA_W  byte address; word index = req_addr_i >> $clog2(DATA_W/8)
req_data_i  input  DATA_W  write data
req_strb_i  input  DATA_W/8  byte write enables
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  host accepts response
rsp_data_o  output  DATA_W  read data (0 for writes and errors)
rsp_err_o  output  1  request rejected
idle_i  input  1  allocator core idle; commit is permitted
config_o  output  NUM_CFG*DATA_W  active config, register k at bits [k*DATA_W +: DATA_W]
config_update_o  output  1  one-cycle pulse when config_o takes new values

Behaviour:
- Reset: one clock `clk_i`; reset is asynchronous and active-low on `rst_ni`. While reset is asserted:
  - shadow, active, pending, locked, err_sticky = 0;
  - rsp_valid_o, rsp_data_o, rsp_err_o, config_update_o = 0;
  - config_o = 0; FSM = IDLE.
- Reset mid-transaction drops the response and any pending commit.
- Address map by word index:
  - 0..NUM_CFG-1: shadow cfg (RW).
  - NUM_CFG: CTRL (W). Bit0 = commit, self-clearing; bit1 = lock, set-only. Reads return {locked, pending}.
  - NUM_CFG+1: STATUS (RO). Bit0 pending, bit1 locked, bit2 err_sticky; a read clears err_sticky and returns the pre-clear value.
  - Index > NUM_CFG+1, or any upper address bit set beyond IDX_W: error.
- FSM:
  - IDLE: req_ready_o = 1. On req_valid_i & req_ready_o, execute the request, register the response, go to RESP.
  - RESP: req_ready_o = 0, rsp_valid_o = 1; rsp_data_o and rsp_err_o stay stable until rsp_ready_i. Back to IDLE on rsp_valid_o & rsp_ready_i.
  - Latency: the response is visible the cycle after acceptance. Throughput: at most one request per 2 cycles; zero-wait host.
- Write to shadow k: bytes with req_strb_i[b]=1 are updated; other bytes are kept. Strobe 0 is legal (no-op, no error).
- Errors (rsp_err_o=1, no state change, err_sticky set):
  - out-of-range index;
  - any write to STATUS;
  - shadow or CTRL write while locked;
  - shadow write while pending.
- Read errors (out of range only) return rsp_data_o = 0.
- Commit:
  - A CTRL write with bit0=1 sets pending at the accepting edge.
  - In any later cycle with pending & idle_i: active <= shadow (all registers in the same edge), pending <= 0, config_update_o <= 1 for exactly one cycle, coincident with the new config_o.
  - Commit write and idle_i in the same cycle: the copy happens no earlier than the next cycle.
  - Commit while already pending: no error; stays a single commit.
  - Commit and lock in the same CTRL write: both take effect, and the pending commit still completes.
- Lock is cleared only by reset.
- Commit proceeds independently of the host FSM state, including during RESP.

Decomposition:
- falafel_pkg:
  - typedef cfg_fsm_e {CFG_IDLE, CFG_RESP};
  - localparams CTRL_COMMIT_BIT=0, CTRL_LOCK_BIT=1, STAT_PEND_BIT=0, STAT_LOCK_BIT=1, STAT_ERR_BIT=2;
  - function cfg_strb_merge(old, new, strb).
- The index-decode and index arithmetic are parametric in NUM_CFG, so they stay in the block rather than the package.
- One natural sub-module: falafel_cfg_strb_reg, a single DATA_W register with byte-strobe write. Instantiated NUM_CFG times for the shadow bank.

Test Plan:
- Reset, then read index 0 and STATUS -> rsp_data_o=0, rsp_err_o=0, config_o=0, req_ready_o=1.
- Write shadow 1 = 0x1122334455667788 with strb 0xFF, then write with strb 0x0F and data 0xAAAAAAAAAAAAAAAA, read back -> 0x11223344AAAAAAAA; config_o unchanged.
- With idle_i=0, write CTRL=0x1 -> STATUS reads 0x1. Raise idle_i -> the next edge updates config_o slice 1 and config_update_o pulses for 1 cycle; STATUS then reads 0x0.
- While pending, write shadow 0 -> rsp_err_o=1, shadow 0 unchanged. Then read STATUS -> 0x5; a second STATUS read -> 0x1.
- Write CTRL=0x2 (lock), then write shadow 2 and CTRL=0x1 -> both rsp_err_o=1. STATUS=0x6; config_o unchanged. Only rst_ni clears the lock.
- Hold rsp_ready_i=0 for 5 cycles after a read -> rsp_valid_o and rsp_data_o stable, req_ready_o=0. Assert rst_ni=0 mid-hold -> rsp_valid_o=0 immediately (async).
